srx_sw_seq: RTL and testbench

Switch-sequencing controller for the SRX observation path. It drives the `ant_sel`/`path_sel`/`band_sel` selection consumed by the PA switch map, and accepts capture requests through a valid/ready handshake. For each request it enforces break-before-make parking, waits for switch settling, then opens a capture-enable window for the DPD/VSWR capture logic.

---
 rtl/srx_ctrl_pkg.sv | 15 +
 rtl/srx_sw_timer.sv | 34 +++
 rtl/srx_sw_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_srx_sw_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/srx_ctrl_pkg.sv
// Shared types and constants for the SRX observation-path switch sequencer.
package srx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARK,
    ST_SETTLE,
    ST_CAPTURE
  } srx_state_e;

  localparam logic [2:0] ANT_PARK       = 3'd7;
  localparam logic       PATH_TYPE_DPD  = 1'b0;
  localparam logic       PATH_TYPE_VSWR = 1'b1;

endpackage

// File: rtl/srx_sw_timer.sv
// Loadable down-counter shared by the PARK, SETTLE and CAPTURE phases.
module srx_sw_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/srx_sw_seq.sv
// SRX switch-sequencing controller: break-before-make park, settle, capture window.
// Optional round-robin antenna scanning is enabled by defining SRX_AUTO_SCAN_EN.
module srx_sw_seq
  import srx_ctrl_pkg::*;
#(
  parameter int NUM_ANT    = 4,
  parameter int GUARD_CYC  = 16,
  parameter int SETTLE_CYC = 200,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_ant,
  input  logic             req_path,
  input  logic             req_band,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
`ifdef SRX_AUTO_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_path,
  input  logic             scan_band,
`endif
  output logic [2:0]       ant_sel,
  output logic             path_sel,
  output logic             band_sel,
  output logic             cap_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_ant
);

  localparam int CNT_MAX = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int CNT_LOG = $clog2(CNT_MAX);
  localparam int TMR_W   = (CNT_LOG > LEN_W) ? CNT_LOG : LEN_W;

  localparam logic [2:0] NUM_ANT_L = 3'(NUM_ANT);

  srx_state_e       state_q, state_d;
  logic [2:0]       ant_sel_q, ant_sel_d;
  logic             path_sel_q, path_sel_d;
  logic             band_sel_q, band_sel_d;
  logic             cap_en_q, cap_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_ant_q, err_ant_d;
  logic             sel_ok_q, sel_ok_d;
  logic [2:0]       lat_ant_q, lat_ant_d;
  logic             lat_path_q, lat_path_d;
  logic             lat_band_q, lat_band_d;
  logic [LEN_W-1:0] lat_len_q, lat_len_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;

  logic             r_go;
  logic [2:0]       r_ant;
  logic             r_path;
  logic             r_band;

`ifdef SRX_AUTO_SCAN_EN
  localparam logic [2:0] ANT_LAST = 3'(NUM_ANT - 1);
  logic [2:0] scan_idx_q, scan_idx_d;
  logic       lat_scan_q, lat_scan_d;
  logic       r_scan;
`endif

  assign req_ready = (state_q == ST_IDLE);

  // Request source: an external request always wins over a scan slot.
  always_comb begin
    r_go   = req_valid;
    r_ant  = req_ant;
    r_path = req_path;
    r_band = req_band;
`ifdef SRX_AUTO_SCAN_EN
    r_scan = 1'b0;
    if (!req_valid && scan_en) begin
      r_go   = 1'b1;
      r_ant  = scan_idx_q;
      r_path = scan_path;
      r_band = scan_band;
      r_scan = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    ant_sel_d  = ant_sel_q;
    path_sel_d = path_sel_q;
    band_sel_d = band_sel_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    err_ant_d  = 1'b0;
    sel_ok_d   = sel_ok_q;
    lat_ant_d  = lat_ant_q;
    lat_path_d = lat_path_q;
    lat_band_d = lat_band_q;
    lat_len_d  = lat_len_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef SRX_AUTO_SCAN_EN
    lat_scan_d = lat_scan_q;
    scan_idx_d = scan_idx_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (r_go) begin
          if (r_ant >= NUM_ANT_L) begin
            err_ant_d = 1'b1;
          end else begin
            lat_ant_d  = r_ant;
            lat_path_d = r_path;
            lat_band_d = r_band;
            lat_len_d  = req_len;
`ifdef SRX_AUTO_SCAN_EN
            lat_scan_d = r_scan;
`endif
            if (sel_ok_q && ({r_ant, r_path, r_band} == {ant_sel_q, path_sel_q, band_sel_q})) begin
              // Switches already settled on this selection: go straight to capture.
              if (req_len == '0) begin
                done_d = 1'b1;
              end else begin
                state_d  = ST_CAPTURE;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(req_len - LEN_W'(1));
              end
            end else begin
              state_d   = ST_PARK;
              ant_sel_d = ANT_PARK;
              sel_ok_d  = 1'b0;
              tmr_load  = 1'b1;
              tmr_val   = TMR_W'(GUARD_CYC - 1);
            end
          end
        end
      end

      ST_PARK: begin
        if (tmr_exp) begin
          state_d    = ST_SETTLE;
          ant_sel_d  = lat_ant_q;
          path_sel_d = lat_path_q;
          band_sel_d = lat_band_q;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(SETTLE_CYC - 1);
        end
      end

      ST_SETTLE: begin
        if (tmr_exp) begin
          sel_ok_d = 1'b1;
          if (lat_len_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_CAPTURE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(lat_len_q - LEN_W'(1));
          end
        end
      end

      ST_CAPTURE: begin
        if (tmr_exp) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any completion decided above.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      ant_sel_d = ANT_PARK;
      sel_ok_d  = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      tmr_load  = 1'b0;
    end

`ifdef SRX_AUTO_SCAN_EN
    if (done_d && lat_scan_d) begin
      scan_idx_d = (scan_idx_q == ANT_LAST) ? 3'd0 : scan_idx_q + 3'd1;
    end
`endif

    cap_en_d = (state_d == ST_CAPTURE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ant_sel_q  <= ANT_PARK;
      path_sel_q <= 1'b0;
      band_sel_q <= 1'b0;
      cap_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_ant_q  <= 1'b0;
      sel_ok_q   <= 1'b0;
      lat_ant_q  <= '0;
      lat_path_q <= 1'b0;
      lat_band_q <= 1'b0;
      lat_len_q  <= '0;
`ifdef SRX_AUTO_SCAN_EN
      scan_idx_q <= '0;
      lat_scan_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ant_sel_q  <= ant_sel_d;
      path_sel_q <= path_sel_d;
      band_sel_q <= band_sel_d;
      cap_en_q   <= cap_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      err_ant_q  <= err_ant_d;
      sel_ok_q   <= sel_ok_d;
      lat_ant_q  <= lat_ant_d;
      lat_path_q <= lat_path_d;
      lat_band_q <= lat_band_d;
      lat_len_q  <= lat_len_d;
`ifdef SRX_AUTO_SCAN_EN
      scan_idx_q <= scan_idx_d;
      lat_scan_q <= lat_scan_d;
`endif
    end
  end

  srx_sw_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state_q != ST_IDLE),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign ant_sel  = ant_sel_q;
  assign path_sel = path_sel_q;
  assign band_sel = band_sel_q;
  assign cap_en   = cap_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign err_ant  = err_ant_q;

endmodule

// File: tb/tb_srx_sw_seq.sv
// Randomized self-checking bench for srx_sw_seq against a transaction-level timeline model.
module tb_srx_sw_seq;

  localparam int NUM_ANT = 4;
  localparam int G       = 16;
  localparam int S       = 200;
  localparam int LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_ant = '0;
  logic             req_path = 1'b0;
  logic             req_band = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic             abort = 1'b0;
  logic [2:0]       ant_sel;
  logic             path_sel, band_sel, cap_en, busy, done, aborted, err_ant;
`ifdef SRX_AUTO_SCAN_EN
  logic             scan_en = 1'b0;
  logic             scan_path = 1'b0;
  logic             scan_band = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model of what the switch map currently sees.
  logic [2:0] m_ant  = 3'd7;
  logic       m_path = 1'b0;
  logic       m_band = 1'b0;
  bit         m_ok   = 1'b0;

  always #5 clk = ~clk;

  srx_sw_seq #(
    .NUM_ANT    (NUM_ANT),
    .GUARD_CYC  (G),
    .SETTLE_CYC (S),
    .LEN_W      (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ant   (req_ant),
    .req_path  (req_path),
    .req_band  (req_band),
    .req_len   (req_len),
    .abort     (abort),
`ifdef SRX_AUTO_SCAN_EN
    .scan_en   (scan_en),
    .scan_path (scan_path),
    .scan_band (scan_band),
`endif
    .ant_sel   (ant_sel),
    .path_sel  (path_sel),
    .band_sel  (band_sel),
    .cap_en    (cap_en),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .err_ant   (err_ant)
  );

  wire [10:0] obs = {req_ready, busy, ant_sel, path_sel, band_sel, cap_en, done, aborted, err_ant};

  function automatic logic [10:0] mk(bit rdy, bit bsy, logic [2:0] an, bit p, bit b,
                                     bit cap, bit dn, bit ab, bit er);
    return {rdy, bsy, an, p, b, cap, dn, ab, er};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", obs, mk(1, 0, m_ant, m_path, m_band, 0, 0, 0, 0));
    end
  endtask

  // One request; ab_at = cycle after acceptance in which abort is held (0 none, <0 random).
  task automatic do_req(input logic [2:0] a, input logic p, input logic b,
                        input logic [LEN_W-1:0] len, input int ab_at, input int tnum);
    bit         inv, fast, cap;
    int         busy_end;
    logic [2:0] cur_a;
    logic       cur_p, cur_b;
    inv  = (int'(a) >= NUM_ANT);
    fast = !inv && m_ok && (a == m_ant) && (p == m_path) && (b == m_band);
    req_valid = 1'b1;
    req_ant   = a;
    req_path  = p;
    req_band  = b;
    req_len   = len;
    check($sformatf("t%0d ready", tnum), req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_len   = LEN_W'($urandom_range(0, 50));
    @(negedge clk);
    if (inv) begin
      check($sformatf("t%0d err", tnum), obs, mk(1, 0, m_ant, m_path, m_band, 0, 0, 0, 1));
      idle_cycles(1);
      return;
    end
    busy_end = fast ? int'(len) : G + S + int'(len);
    if (ab_at < 0) ab_at = (busy_end > 0) ? int'($urandom_range(1, busy_end)) : 0;
    for (int c = 1; c <= busy_end + 1; c++) begin
      if (fast || c > G) begin
        cur_a = a; cur_p = p; cur_b = b;
      end else begin
        cur_a = 3'd7; cur_p = m_path; cur_b = m_band;
      end
      cap = fast ? (c <= int'(len)) : (c > G + S && c <= G + S + int'(len));
      check($sformatf("t%0d c%0d", tnum, c), obs,
            mk(c > busy_end, c <= busy_end, cur_a, cur_p, cur_b, cap, c == busy_end + 1, 0, 0));
      if (c == ab_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check($sformatf("t%0d abort", tnum), obs, mk(1, 0, 3'd7, cur_p, cur_b, 0, 0, 1, 0));
        m_ant = 3'd7; m_path = cur_p; m_band = cur_b; m_ok = 1'b0;
        return;
      end
      if (c <= busy_end) @(negedge clk);
    end
    m_ant = a; m_path = p; m_band = b; m_ok = 1'b1;
  endtask

  initial begin
    logic [2:0]       ra;
    logic             rp, rb;
    logic [LEN_W-1:0] rl;

    repeat (3) @(negedge clk);
    check("reset", obs, mk(1, 0, 3'd7, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    idle_cycles(2);

    do_req(3'd2, 1'b0, 1'b1, 16'd8, 0, 1);   // full park/settle path
    do_req(3'd2, 1'b0, 1'b1, 16'd8, 0, 2);   // identical: fast path
    do_req(3'd5, 1'b0, 1'b0, 16'd8, 0, 3);   // invalid antenna
    do_req(3'd1, 1'b1, 1'b0, 16'd4, 100, 4); // abort in SETTLE
    do_req(3'd1, 1'b1, 1'b0, 16'd4, 0, 5);   // must take full path again
    do_req(3'd3, 1'b0, 1'b0, 16'd0, 0, 6);   // zero length
    do_req(3'd3, 1'b0, 1'b0, 16'd0, 0, 7);   // zero length on fast path
    idle_cycles(1);

    // Asynchronous reset in the middle of a settle phase.
    req_valid = 1'b1; req_ant = 3'd1; req_path = 1'b1; req_band = 1'b1; req_len = 16'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1 check("rst async", obs, mk(1, 0, 3'd7, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    m_ant = 3'd7; m_path = 1'b0; m_band = 1'b0; m_ok = 1'b0;
    idle_cycles(2);

    ra = 3'd0; rp = 1'b0; rb = 1'b0;
    for (int t = 0; t < 26; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        ra = 3'($urandom_range(0, 6));
        rp = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
      end
      rl = LEN_W'($urandom_range(0, 12));
      do_req(ra, rp, rb, rl, ($urandom_range(0, 3) == 0) ? -1 : 0, 100 + t);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
